// File: rtl/writeback_unit_pkg.sv
// Shared writeback types and constants for the register-file write path.
package writeback_unit_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_unit_fifo.sv
// wb_fifo: DEPTH-entry write queue; a push is visible after its edge, all slots are exposed for lookup.
// Pushes while full and pops while empty are ignored; the producer holds its offer until space frees.
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [ADDR_W-1:0]             push_reg_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [CNT_W-1:0]              count_o,
  output logic [PTR_W-1:0]              head_o,
  output logic [ADDR_W-1:0]             head_reg_o,
  output logic [DATA_W-1:0]             head_data_o,
  output logic [DEPTH-1:0]              ent_vld_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_reg_o,
  output logic [DEPTH-1:0][DATA_W-1:0]  ent_data_o
);
  import writeback_unit_pkg::*;

  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][ADDR_W-1:0] reg_q, reg_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    vld_d   = vld_q;
    reg_d   = reg_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_W'(1);
    end
    if (do_push) begin
      vld_d[tail_q]  = 1'b1;
      reg_d[tail_q]  = push_reg_i;
      data_d[tail_q] = push_data_i;
      tail_d         = tail_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign head_o      = head_q;
  assign head_reg_o  = reg_q[head_q];
  assign head_data_o = data_q[head_q];
  assign ent_vld_o   = vld_q;
  assign ent_reg_o   = reg_q;
  assign ent_data_o  = data_q;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: queues retiring results and drains one register-file write per cycle; 1 cycle accept-to-write when idle.
// inReady drops while the queue is full (no same-cycle pop credit); WB_FORWARD_EN builds the pending-write lookups.
module writeback_unit #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = writeback_unit_pkg::DATA_W,
  parameter int ADDR_W = writeback_unit_pkg::ADDR_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic              inRegWrite,
  input  logic              inMemToReg,
  input  logic [ADDR_W-1:0] inWriteReg,
  input  logic [DATA_W-1:0] inAluResult,
  input  logic [DATA_W-1:0] inMemData,
  input  logic              wbStall,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] fwdReg1,
  input  logic [ADDR_W-1:0] fwdReg2,
  output logic              fwdHit1,
  output logic              fwdHit2,
  output logic [DATA_W-1:0] fwdData1,
  output logic [DATA_W-1:0] fwdData2,
  output logic [CNT_W-1:0]  pendingCount
);
  import writeback_unit_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic                         full, empty, push, pop;
  logic [DATA_W-1:0]            in_data, head_data;
  logic [ADDR_W-1:0]            head_reg;
  logic [PTR_W-1:0]             head_ptr;
  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_reg;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;

  assign inReady = ~full;
  assign in_data = inMemToReg ? inMemData : inAluResult;
  // $0 and non-writing results complete the handshake but never occupy a slot
  assign push    = inValid & inReady & inRegWrite & (inWriteReg != REG_ZERO);
  assign pop     = ~empty & ~wbStall;

  assign regWrite  = pop;
  assign writeReg  = pop ? head_reg  : '0;
  assign writeData = pop ? head_data : '0;

  wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_reg_i  (inWriteReg),
    .push_data_i (in_data),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (pendingCount),
    .head_o      (head_ptr),
    .head_reg_o  (head_reg),
    .head_data_o (head_data),
    .ent_vld_o   (ent_vld),
    .ent_reg_o   (ent_reg),
    .ent_data_o  (ent_data)
  );

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest from head so the last match wins
  always_comb begin
    fwdHit1  = 1'b0;
    fwdHit2  = 1'b0;
    fwdData1 = '0;
    fwdData2 = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PTR_W'(i);
      if (ent_vld[idx] && (ent_reg[idx] == fwdReg1) && (fwdReg1 != REG_ZERO)) begin
        fwdHit1  = 1'b1;
        fwdData1 = ent_data[idx];
      end
      if (ent_vld[idx] && (ent_reg[idx] == fwdReg2) && (fwdReg2 != REG_ZERO)) begin
        fwdHit2  = 1'b1;
        fwdData2 = ent_data[idx];
      end
    end
  end
`else
  logic fwd_unused;
  assign fwd_unused = ^{fwdReg1, fwdReg2, head_ptr, ent_vld, ent_reg, ent_data};
  assign fwdHit1    = 1'b0;
  assign fwdHit2    = 1'b0;
  assign fwdData1   = '0;
  assign fwdData2   = '0;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus queues expected writes, a negedge monitor checks the write port.
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        inValid, inReady, inRegWrite, inMemToReg, wbStall;
  logic [4:0]  inWriteReg, writeReg, fwdReg1, fwdReg2;
  logic [31:0] inAluResult, inMemData, writeData, fwdData1, fwdData2;
  logic        regWrite, fwdHit1, fwdHit2;
  logic [2:0]  pendingCount;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   base, w;
  logic wrap_done;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .rst(rst),
    .inValid(inValid), .inReady(inReady), .inRegWrite(inRegWrite), .inMemToReg(inMemToReg),
    .inWriteReg(inWriteReg), .inAluResult(inAluResult), .inMemData(inMemData),
    .wbStall(wbStall), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .fwdReg1(fwdReg1), .fwdReg2(fwdReg2), .fwdHit1(fwdHit1), .fwdHit2(fwdHit2),
    .fwdData1(fwdData1), .fwdData2(fwdData2), .pendingCount(pendingCount)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Offer one result; returns the number of edges until it was taken
  task automatic send(input logic [4:0] r, input logic [31:0] alu, input logic [31:0] mem,
                      input logic m2r, input logic rw, input logic exp_wr,
                      input logic [31:0] exp_dat, output int waited);
    logic rdy;
    inValid = 1'b1; inWriteReg = r; inAluResult = alu; inMemData = mem;
    inMemToReg = m2r; inRegWrite = rw;
    waited = 0;
    do begin
      @(negedge clk);
      rdy = inReady;
      @(posedge clk);
      waited++;
    end while (!rdy && waited < 50);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: actual no accept after %0d cycles, required accept", waited);
    end else if (exp_wr) begin
      sb.push_back({r, exp_dat});
    end
    #1 inValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pendingCount != 3'd0 && n < 60);
    chk("drain_count", 32'(pendingCount), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (regWrite) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: actual reg %0d data 0x%08h, required no write", writeReg, writeData);
        end else begin
          e = sb.pop_front();
          chk("write_reg", 32'(writeReg), 32'(e.r));
          chk("write_data", writeData, e.d);
        end
        wr_cnt++;
      end else begin
        chk("idle_reg", 32'(writeReg), 32'd0);
        chk("idle_data", writeData, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    inValid = 0; inRegWrite = 0; inMemToReg = 0; inWriteReg = 0;
    inAluResult = 0; inMemData = 0; wbStall = 0; fwdReg1 = 0; fwdReg2 = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_writeReg", 32'(writeReg), 32'd0);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_pending", 32'(pendingCount), 32'd0);
    chk("rst_fwdHit1", 32'(fwdHit1), 32'd0);
    chk("rst_fwdData2", fwdData2, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_inReady", 32'(inReady), 32'd1);
    @(posedge clk);
    #1;

    // Reset with three writes pending: none may ever reach the port
    wbStall = 1'b1;
    send(5'd5, 32'h5, 32'h0, 1'b0, 1'b1, 1'b1, 32'h5, w);
    send(5'd6, 32'h6, 32'h0, 1'b0, 1'b1, 1'b1, 32'h6, w);
    send(5'd7, 32'h7, 32'h0, 1'b0, 1'b1, 1'b1, 32'h7, w);
    @(negedge clk);
    chk("pre_rst_pending", 32'(pendingCount), 32'd3);
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #2;
    chk("mid_rst_pending", 32'(pendingCount), 32'd0);
    chk("mid_rst_regWrite", 32'(regWrite), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wbStall = 1'b0;
    @(negedge clk);
    chk("post_rst_inReady", 32'(inReady), 32'd1);
    chk("post_rst_pending", 32'(pendingCount), 32'd0);
    repeat (4) @(posedge clk);
    #1;

    // Single ALU write, one-cycle latency
    send(5'd8, 32'h0000_1234, 32'hFFFF_0000, 1'b0, 1'b1, 1'b1, 32'h0000_1234, w);
    @(negedge clk);
    chk("alu_regWrite", 32'(regWrite), 32'd1);
    chk("alu_writeReg", 32'(writeReg), 32'd8);
    chk("alu_writeData", writeData, 32'h0000_1234);
    @(negedge clk);
    chk("alu_after", 32'(regWrite), 32'd0);
    @(posedge clk);
    #1;

    // Load select, then $0 and non-writing results
    send(5'd9, 32'h0000_5555, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, w);
    @(negedge clk);
    chk("load_writeData", writeData, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    send(5'd0, 32'h77, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, w);
    @(negedge clk);
    chk("r0_pending", 32'(pendingCount), 32'd0);
    chk("r0_regWrite", 32'(regWrite), 32'd0);
    @(posedge clk);
    #1;
    send(5'd10, 32'h99, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, w);
    @(negedge clk);
    chk("norw_pending", 32'(pendingCount), 32'd0);
    @(posedge clk);
    #1;

    // Stall fill: four fit, fifth taken on the second pop edge
    wbStall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(5'(i + 1), 32'h100 + i, 32'h0, 1'b0, 1'b1, 1'b1, 32'h100 + i, w);
      chk("fill_wait", 32'(w), 32'd1);
    end
    @(negedge clk);
    chk("full_pending", 32'(pendingCount), 32'd4);
    chk("full_inReady", 32'(inReady), 32'd0);
    @(posedge clk);
    #1;
    base = wr_cnt;
    wbStall = 1'b0;
    send(5'd5, 32'h104, 32'h0, 1'b0, 1'b1, 1'b1, 32'h104, w);
    chk("fifth_accept_edges", 32'(w), 32'd2);
    chk("writes_before_fifth", 32'(wr_cnt - base), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_consecutive", 32'(regWrite), 32'd1);
    end
    @(negedge clk);
    chk("drain_done", 32'(regWrite), 32'd0);
    @(posedge clk);
    #1;

    // Forwarding: youngest wins, same-cycle accept invisible, head still hits
    wbStall = 1'b1;
    fwdReg1 = 5'd3;
    fwdReg2 = 5'd0;
    send(5'd3, 32'h11, 32'h0, 1'b0, 1'b1, 1'b1, 32'h11, w);
    send(5'd3, 32'h22, 32'h0, 1'b0, 1'b1, 1'b1, 32'h22, w);
    @(negedge clk);
    chk("fwd_hit1", 32'(fwdHit1), 32'(FWD));
    chk("fwd_data1", fwdData1, FWD ? 32'h22 : 32'h0);
    chk("fwd_hit2_r0", 32'(fwdHit2), 32'd0);
    chk("fwd_data2_r0", fwdData2, 32'd0);
    @(posedge clk);
    #1;
    fwdReg1 = 5'd7;
    inValid = 1'b1; inWriteReg = 5'd7; inAluResult = 32'h77; inMemData = 32'h0;
    inMemToReg = 1'b0; inRegWrite = 1'b1;
    @(negedge clk);
    chk("fwd_same_cycle_hit", 32'(fwdHit1), 32'd0);
    chk("fwd_same_cycle_rdy", 32'(inReady), 32'd1);
    @(posedge clk);
    sb.push_back({5'd7, 32'h77});
    #1 inValid = 1'b0;
    @(negedge clk);
    chk("fwd_next_cycle_hit", 32'(fwdHit1), 32'(FWD));
    chk("fwd_next_cycle_data", fwdData1, FWD ? 32'h77 : 32'h0);
    @(posedge clk);
    #1;
    fwdReg1 = 5'd3;
    wbStall = 1'b0;
    @(negedge clk);
    chk("fwd_drainA_data", fwdData1, FWD ? 32'h22 : 32'h0);
    @(negedge clk);
    chk("fwd_head_reg", 32'(writeReg), 32'd3);
    chk("fwd_head_hit", 32'(fwdHit1), 32'(FWD));
    chk("fwd_head_data", fwdData1, FWD ? 32'h22 : 32'h0);
    @(negedge clk);
    chk("fwd_gone_hit", 32'(fwdHit1), 32'd0);
    chk("fwd_gone_data", fwdData1, 32'd0);
    drain();

    // Wrap-around with the stall toggling every cycle
    base = wr_cnt;
    wrap_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send(5'(i + 1), 32'hA000_0000 + i, 32'hB000_0000 + i, i[0], 1'b1, 1'b1,
               i[0] ? 32'hB000_0000 + i : 32'hA000_0000 + i, w);
        end
        wrap_done = 1'b1;
      end
      begin
        while (!wrap_done) begin
          @(posedge clk);
          #1 wbStall = ~wbStall;
        end
      end
    join
    wbStall = 1'b0;
    drain();
    chk("wrap_write_count", 32'(wr_cnt - base), 32'd12);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
